// File: rtl/line_sensor_tracker_if.sv
// line_sensor_tracker_if
//   Bundles the ADC-side inputs (sweep phase and the three line-sensor
//   readings) with the tracker results consumed by the motion controller.
//   master : drives data_frame / d_out_ch5..7, observes the tracker outputs.
//   slave  : the tracker itself.
interface line_sensor_tracker_if;
  logic [1:0]        data_frame;
  logic [11:0]       d_out_ch5;
  logic [11:0]       d_out_ch6;
  logic [11:0]       d_out_ch7;
  logic [2:0]        line_bits;
  logic signed [2:0] line_err;
  logic              sample_valid;
  logic              node_pulse;
  logic [3:0]        node_count;
  logic              line_lost;

  modport master (
    output data_frame, d_out_ch5, d_out_ch6, d_out_ch7,
    input  line_bits, line_err, sample_valid, node_pulse, node_count, line_lost
  );

  modport slave (
    input  data_frame, d_out_ch5, d_out_ch6, d_out_ch7,
    output line_bits, line_err, sample_valid, node_pulse, node_count, line_lost
  );
endinterface

// File: rtl/line_sensor_tracker.sv
// line_sensor_tracker
//   Per-sweep processing of the left/centre/right line sensors: 4-sweep
//   moving average, hysteresis classification, debounce, then steering
//   error, junction (node) detection and line-lost detection.
//   clk_50 : system clock, all logic on posedge
//   rst    : synchronous active-high reset
//   bus    : slave side of line_sensor_tracker_if
//            in : data_frame, d_out_ch5 (left), d_out_ch6 (centre), d_out_ch7 (right)
//            out: line_bits, line_err, sample_valid, node_pulse, node_count, line_lost
//   Pipeline (T = sweep_done cycle, each stage registers at the end of its cycle):
//     T capture windows, T+1 average, T+2 class/debounce, T+3 outputs.
module line_sensor_tracker #(
  parameter logic [11:0] TH_HI       = 12'd2000,
  parameter logic [11:0] TH_LO       = 12'd1000,
  parameter logic [2:0]  DEBOUNCE    = 3'd2,
  parameter logic [3:0]  NODE_SWEEPS = 4'd3,
  parameter logic [3:0]  LOST_SWEEPS = 4'd8
) (
  input logic                  clk_50,
  input logic                  rst,
  line_sensor_tracker_if.slave bus
);

  // channel index matches line_bits position: 2 = left, 1 = centre, 0 = right
  logic [1:0]  df_s1, df_s2, df_prev;
  logic        sweep_done;
  logic [11:0] ch_in   [0:2];
  logic [11:0] win     [0:2][0:3];
  logic [11:0] avg     [0:2];
  logic [11:0] avg_nxt [0:2];
  logic [2:0]  cls, cls_nxt;
  logic [2:0]  db;
  logic [2:0]  db_cnt  [0:2];
  logic [2:0]  prime_cnt;
  logic        v0, v1, v2;
  logic        p0, p1, p2;
  logic [3:0]  node_run, lost_run, lost_nxt;

  logic [2:0]        line_bits_q;
  logic signed [2:0] line_err_q, err_nxt;
  logic              sample_valid_q, node_pulse_q, line_lost_q;
  logic [3:0]        node_count_q;

  assign sweep_done = (df_prev == 2'd2) && (df_s2 == 2'd0);

  assign ch_in[2] = bus.d_out_ch5;
  assign ch_in[1] = bus.d_out_ch6;
  assign ch_in[0] = bus.d_out_ch7;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      logic [13:0] sum;
      sum = 14'(win[i][0]) + 14'(win[i][1]) + 14'(win[i][2]) + 14'(win[i][3]);
      avg_nxt[i] = 12'(sum >> 2);
      if (avg[i] >= TH_HI)      cls_nxt[i] = 1'b1;
      else if (avg[i] <= TH_LO) cls_nxt[i] = 1'b0;
      else                      cls_nxt[i] = cls[i];
    end
  end

  always_comb begin
    err_nxt = line_err_q;
    case (db)
      3'b100: err_nxt = -3'sd2;
      3'b110: err_nxt = -3'sd1;
      3'b010: err_nxt = 3'sd0;
      3'b011: err_nxt = 3'sd1;
      3'b001: err_nxt = 3'sd2;
      3'b111: err_nxt = 3'sd0;
      3'b101: err_nxt = 3'sd0;
      default: err_nxt = line_err_q;  // 000: no line seen, keep last steering
    endcase
    lost_nxt = (lost_run == 4'hF) ? lost_run : lost_run + 4'd1;
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      df_s1          <= '0;
      df_s2          <= '0;
      df_prev        <= '0;
      cls            <= '0;
      db             <= '0;
      prime_cnt      <= '0;
      {v0, v1, v2}   <= '0;
      {p0, p1, p2}   <= '0;
      node_run       <= '0;
      lost_run       <= '0;
      line_bits_q    <= '0;
      line_err_q     <= '0;
      sample_valid_q <= 1'b0;
      node_pulse_q   <= 1'b0;
      node_count_q   <= '0;
      line_lost_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        avg[i]    <= '0;
        db_cnt[i] <= '0;
        for (int j = 0; j < 4; j++) win[i][j] <= '0;
      end
    end else begin
      df_s1   <= bus.data_frame;
      df_s2   <= df_s1;
      df_prev <= df_s2;

      // stage T: capture; the primed tag travels with the sweep so that
      // back-to-back sweeps are each judged by their own position
      v0 <= sweep_done;
      p0 <= sweep_done && (prime_cnt >= 3'd3);
      if (sweep_done) begin
        for (int i = 0; i < 3; i++) begin
          win[i][3] <= win[i][2];
          win[i][2] <= win[i][1];
          win[i][1] <= win[i][0];
          win[i][0] <= ch_in[i];
        end
        if (prime_cnt != 3'd4) prime_cnt <= prime_cnt + 3'd1;
      end

      // stage T+1: average
      v1 <= v0;
      p1 <= p0;
      if (v0) begin
        for (int i = 0; i < 3; i++) avg[i] <= avg_nxt[i];
      end

      // stage T+2: hysteresis + debounce (runs during priming too)
      v2 <= v1;
      p2 <= p1;
      if (v1) begin
        for (int i = 0; i < 3; i++) begin
          cls[i] <= cls_nxt[i];
          if (cls_nxt[i] == db[i]) begin
            db_cnt[i] <= '0;
          end else if (db_cnt[i] + 3'd1 == DEBOUNCE) begin
            db[i]     <= cls_nxt[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 3'd1;
          end
        end
      end

      // stage T+3: published outputs
      sample_valid_q <= 1'b0;
      node_pulse_q   <= 1'b0;
      if (v2 && p2) begin
        sample_valid_q <= 1'b1;
        line_bits_q    <= db;
        line_err_q     <= err_nxt;

        if (db == 3'b111) begin
          if (node_run != 4'hF) node_run <= node_run + 4'd1;
          // run counter passes NODE_SWEEPS-1 only once per 111 run
          if (node_run == NODE_SWEEPS - 4'd1) begin
            node_pulse_q <= 1'b1;
            if (node_count_q != 4'hF) node_count_q <= node_count_q + 4'd1;
          end
        end else begin
          node_run <= '0;
        end

        if (db == 3'b000) begin
          lost_run <= lost_nxt;
          if (lost_nxt >= LOST_SWEEPS) line_lost_q <= 1'b1;
        end else begin
          lost_run    <= '0;
          line_lost_q <= 1'b0;
        end
      end
    end
  end

  assign bus.line_bits    = line_bits_q;
  assign bus.line_err     = line_err_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.node_pulse   = node_pulse_q;
  assign bus.node_count   = node_count_q;
  assign bus.line_lost    = line_lost_q;

endmodule

// File: tb/tb_line_sensor_tracker.sv
// tb_line_sensor_tracker
//   Drives ADC-style sweeps (data_frame 1,2,0) and checks every sweep
//   against a sweep-level reference model of the tracker, plus a table of
//   settled line positions and hand-written node / lost / reset sequences.
module tb_line_sensor_tracker;
  logic clk_50 = 1'b0;
  logic rst    = 1'b0;

  line_sensor_tracker_if bus ();

  line_sensor_tracker dut (
    .clk_50 (clk_50),
    .rst    (rst),
    .bus    (bus)
  );

  always #10 clk_50 = ~clk_50;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int l;
    int c;
    int r;
    int n;
    int exp_bits;
    int exp_err;
  } row_t;

  row_t rows[$];

  // reference model state (sweep level)
  int hist [3][4];
  int m_cls [3];
  int m_db  [3];
  int m_run [3];
  int m_sweeps, m_bits, m_err, m_node_run, m_node_count, m_lost_run, m_lost;
  int exp_sv, exp_pulse;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) hist[i][j] = 0;
      m_cls[i] = 0; m_db[i] = 0; m_run[i] = 0;
    end
    m_sweeps = 0; m_bits = 0; m_err = 0; m_node_run = 0;
    m_node_count = 0; m_lost_run = 0; m_lost = 0;
  endtask

  task automatic model_sweep(input int l, input int c, input int r);
    int v [3];
    int avg;
    v[2] = l; v[1] = c; v[0] = r;
    for (int i = 0; i < 3; i++) begin
      for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = v[i];
      avg = (hist[i][0] + hist[i][1] + hist[i][2] + hist[i][3]) / 4;
      if (avg >= 2000)      m_cls[i] = 1;
      else if (avg <= 1000) m_cls[i] = 0;
      if (m_cls[i] == m_db[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == 2) begin m_db[i] = m_cls[i]; m_run[i] = 0; end
      end
    end
    m_sweeps++;
    exp_sv    = (m_sweeps >= 4) ? 1 : 0;
    exp_pulse = 0;
    if (exp_sv == 1) begin
      m_bits = m_db[2] * 4 + m_db[1] * 2 + m_db[0];
      case (m_bits)
        4: m_err = -2;
        6: m_err = -1;
        3: m_err = 1;
        1: m_err = 2;
        0: m_err = m_err;
        default: m_err = 0;
      endcase
      if (m_bits == 7) begin
        m_node_run++;
        if (m_node_run == 3) begin
          exp_pulse = 1;
          if (m_node_count < 15) m_node_count++;
        end
      end else m_node_run = 0;
      if (m_bits == 0) begin
        m_lost_run++;
        if (m_lost_run >= 8) m_lost = 1;
      end else begin
        m_lost_run = 0;
        m_lost = 0;
      end
    end
  endtask

  task automatic start_sweep(input int l, input int c, input int r, input bit glitch);
    @(negedge clk_50);
    bus.d_out_ch5 = 12'(l);
    bus.d_out_ch6 = 12'(c);
    bus.d_out_ch7 = 12'(r);
    bus.data_frame = 2'd1;
    repeat (3) @(negedge clk_50);
    bus.data_frame = 2'd2;
    repeat (3) @(negedge clk_50);
    if (glitch) begin
      bus.data_frame = 2'd1;
      repeat (3) @(negedge clk_50);
      bus.data_frame = 2'd2;
      repeat (3) @(negedge clk_50);
    end
  endtask

  // Drop data_frame to 0, watch a fixed window, then compare with the model.
  task automatic finish_sweep(input int l, input int c, input int r);
    int sv_cnt, sv_first, p_cnt;
    sv_cnt = 0; sv_first = 0; p_cnt = 0;
    bus.data_frame = 2'd0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_50);
      if (bus.sample_valid) begin
        sv_cnt++;
        if (sv_first == 0) sv_first = k;
      end
      if (bus.node_pulse) p_cnt++;
    end
    model_sweep(l, c, r);
    check("sample_valid_count", sv_cnt, exp_sv);
    if (exp_sv == 1) check("sample_valid_latency", sv_first, 6);
    check("node_pulse_count", p_cnt, exp_pulse);
    check("line_bits", int'(bus.line_bits), m_bits);
    check("line_err", int'($signed(bus.line_err)), m_err);
    check("node_count", int'(bus.node_count), m_node_count);
    check("line_lost", int'(bus.line_lost), m_lost);
  endtask

  task automatic do_sweep(input int l, input int c, input int r, input bit glitch);
    start_sweep(l, c, r, glitch);
    finish_sweep(l, c, r);
  endtask

  task automatic run_row(input row_t rw);
    for (int s = 0; s < rw.n; s++) do_sweep(rw.l, rw.c, rw.r, 1'b0);
    check("row_line_bits", int'(bus.line_bits), rw.exp_bits);
    check("row_line_err", int'($signed(bus.line_err)), rw.exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_line_bits"},    int'(bus.line_bits), 0);
    check({tag, "_line_err"},     int'($signed(bus.line_err)), 0);
    check({tag, "_sample_valid"}, int'(bus.sample_valid), 0);
    check({tag, "_node_pulse"},   int'(bus.node_pulse), 0);
    check({tag, "_node_count"},   int'(bus.node_count), 0);
    check({tag, "_line_lost"},    int'(bus.line_lost), 0);
  endtask

  initial begin
    int vals [3];
    int pick;

    bus.data_frame = 2'd0;
    bus.d_out_ch5  = '0;
    bus.d_out_ch6  = '0;
    bus.d_out_ch7  = '0;

    // tracking rows: centre start, left-to-right sweep, hysteresis hold,
    // one-sweep dark glitch in a light run
    rows.push_back('{223,  2730, 223,  6, 3'b010,  0});
    rows.push_back('{2730, 223,  223,  6, 3'b100, -2});
    rows.push_back('{2730, 2730, 223,  6, 3'b110, -1});
    rows.push_back('{223,  2730, 223,  6, 3'b010,  0});
    rows.push_back('{223,  2730, 2730, 6, 3'b011,  1});
    rows.push_back('{223,  223,  2730, 6, 3'b001,  2});
    rows.push_back('{223,  2730, 223,  6, 3'b010,  0});
    for (int k = 0; k < 6; k++)
      rows.push_back('{223, (k % 2 == 0) ? 1500 : 1600, 223, 1, 3'b010, 0});
    rows.push_back('{2730, 223,  223,  6, 3'b100, -2});
    rows.push_back('{2730, 4095, 223,  1, 3'b100, -2});
    rows.push_back('{2730, 223,  223,  3, 3'b100, -2});

    @(negedge clk_50);
    rst = 1'b1;
    repeat (2) @(negedge clk_50);
    rst = 1'b0;
    model_reset();
    check_all_zero("reset");

    foreach (rows[i]) run_row(rows[i]);

    // junctions: 7 all-dark sweeps then back to centre, 16 times
    for (int rep = 0; rep < 16; rep++) begin
      run_row('{2730, 2730, 2730, 7, 3'b111, 0});
      run_row('{223,  2730, 223,  6, 3'b010, 0});
      if (rep == 0) check("node_count_first", int'(bus.node_count), 1);
    end
    check("node_count_saturated", int'(bus.node_count), 15);

    // line lost with steering held at +1, then recovery
    run_row('{223, 2730, 2730, 6,  3'b011, 1});
    run_row('{223, 223,  223,  14, 3'b000, 1});
    check("line_lost_set", int'(bus.line_lost), 1);
    run_row('{223, 2730, 223,  5,  3'b010, 0});
    check("line_lost_cleared", int'(bus.line_lost), 0);

    // reset between data_frame=1 and 2
    @(negedge clk_50);
    bus.data_frame = 2'd1;
    repeat (3) @(negedge clk_50);
    rst = 1'b1;
    @(negedge clk_50);
    rst = 1'b0;
    model_reset();
    check_all_zero("midreset");
    bus.data_frame = 2'd2;
    repeat (3) @(negedge clk_50);
    finish_sweep(223, 2730, 223);
    for (int s = 0; s < 5; s++) do_sweep(223, 2730, 223, 1'b0);

    // randomized sweeps, biased toward clear dark/light readings
    for (int s = 0; s < 60; s++) begin
      for (int i = 0; i < 3; i++) begin
        pick = int'($urandom_range(0, 3));
        if (pick == 0)      vals[i] = 223;
        else if (pick == 1) vals[i] = 2730;
        else                vals[i] = int'($urandom_range(0, 4095));
      end
      do_sweep(vals[2], vals[1], vals[0], (s % 10) == 9);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
